// File: rtl/wb_bram_pkg.sv
// Shared definitions for the Wishbone block-RAM slave: controller state
// encoding, default RAM read latency and the byte-lane merge helper.
package wb_bram_pkg;

    localparam int READ_LATENCY_DEF = 2;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_WAIT = 2'd1;
    localparam logic [1:0] ST_WRITE   = 2'd2;
    localparam logic [1:0] ST_ACK     = 2'd3;

    // Lanes with sel set take the new byte, all others keep the stored byte.
    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  sel
    );
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/wb_bram_ctrl.sv
// Wishbone classic single-beat slave in front of a block RAM with a fixed
// read latency; partial byte-select writes become read-modify-write.
module wb_bram_ctrl
    import wb_bram_pkg::*;
#(
    parameter int ADDR_WIDTH   = 13,
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = READ_LATENCY_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_we_i,
    input  logic [3:0]            wbs_sel_i,
    input  logic [31:0]           wbs_adr_i,
    input  logic [31:0]           wbs_dat_i,
    output logic [31:0]           wbs_dat_o,
    output logic                  wbs_ack_o,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_write_address,
    output logic [ADDR_WIDTH-1:0] mem_read_address,
    output logic [31:0]           mem_data_in,
    input  logic [31:0]           mem_data_out,
    output logic [1:0]            dbg_state
);

    // Handshake: a request is taken in IDLE when cyc & stb are high; ack is
    // then held until the master drops stb (or cyc), and dropping cyc before
    // ack abandons the transfer without an ack.

    localparam int CW = $clog2(READ_LATENCY + 2);

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [CW-1:0]         cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdat_q;
    logic [3:0]            sel_q;
    logic                  we_q;
    logic [31:0]           dat_o_q;
    logic [31:0]           mem_din_q;
    logic                  accept;
    logic                  in_range;
    logic                  rd_done;
    logic                  adr_high_unused;

    assign adr_high_unused = ^wbs_adr_i[31:ADDR_WIDTH];

    assign accept   = (state == ST_IDLE) && wbs_cyc_i && wbs_stb_i && !wbs_ack_o;
    assign in_range = wbs_adr_i[ADDR_WIDTH-1:0] < ADDR_WIDTH'(DEPTH);
    // One edge beyond the RAM latency so the registered output has settled.
    assign rd_done  = (cnt == CW'(READ_LATENCY));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (!in_range) begin
                        state_nxt = ST_ACK;
                    end else if (wbs_we_i && wbs_sel_i == 4'hF) begin
                        state_nxt = ST_WRITE;
                    end else if (wbs_we_i && wbs_sel_i == 4'h0) begin
                        state_nxt = ST_ACK;
                    end else begin
                        state_nxt = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (!wbs_cyc_i) begin
                    state_nxt = ST_IDLE;
                end else if (rd_done) begin
                    state_nxt = we_q ? ST_WRITE : ST_ACK;
                end
            end
            ST_WRITE: begin
                state_nxt = wbs_cyc_i ? ST_ACK : ST_IDLE;
            end
            ST_ACK: begin
                if (!wbs_stb_i || !wbs_cyc_i) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        wbs_ack_o = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        case (state)
            ST_RD_WAIT: mem_en = 1'b1;
            ST_WRITE: begin
                mem_en = 1'b1;
                mem_we = 1'b1;
            end
            ST_ACK:   wbs_ack_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            wdat_q    <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            cnt       <= '0;
            dat_o_q   <= '0;
            mem_din_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        addr_q    <= wbs_adr_i[ADDR_WIDTH-1:0];
                        wdat_q    <= wbs_dat_i;
                        sel_q     <= wbs_sel_i;
                        we_q      <= wbs_we_i;
                        cnt       <= '0;
                        dat_o_q   <= '0;
                        mem_din_q <= wbs_dat_i;
                    end
                end
                ST_RD_WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (rd_done) begin
                        if (we_q) begin
                            mem_din_q <= byte_merge(mem_data_out, wdat_q, sel_q);
                        end else begin
                            dat_o_q <= mem_data_out;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign wbs_dat_o         = dat_o_q;
    assign mem_data_in       = mem_din_q;
    assign mem_write_address = addr_q;
    assign mem_read_address  = addr_q;
    assign dbg_state         = state;

endmodule

// File: tb/tb_wb_bram_ctrl.sv
// Bench for wb_bram_ctrl: behavioural RAM, shadow memory model with
// transaction-level timing expectations, directed cases then random traffic.
module tb_wb_bram_ctrl;

    localparam int AW    = 13;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wbs_cyc_i = 1'b0;
    logic          wbs_stb_i = 1'b0;
    logic          wbs_we_i = 1'b0;
    logic [3:0]    wbs_sel_i = 4'h0;
    logic [31:0]   wbs_adr_i = '0;
    logic [31:0]   wbs_dat_i = '0;
    logic [31:0]   wbs_dat_o;
    logic          wbs_ack_o;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_write_address;
    logic [AW-1:0] mem_read_address;
    logic [31:0]   mem_data_in;
    logic [31:0]   mem_data_out = '0;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;

    logic [31:0] ram     [0:DEPTH-1];
    logic [31:0] ref_mem [0:DEPTH-1];
    logic [AW-1:0] ram_raddr_q = '0;
    logic        ram_init = 1'b0;
    logic [31:0] exp_q[$];

    wb_bram_ctrl dut (
        .clk(clk), .rst(rst),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o),
        .mem_en(mem_en), .mem_we(mem_we),
        .mem_write_address(mem_write_address), .mem_read_address(mem_read_address),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] seed_word(input int i);
        return (32'(i) * 32'h9E3779B1) + 32'h01234567;
    endfunction

    // Block RAM: address register gated by en, then an output register.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= seed_word(i);
        end else if (mem_en) begin
            ram_raddr_q <= mem_read_address;
            if (mem_we && int'(mem_write_address) < DEPTH) ram[mem_write_address] <= mem_data_in;
        end
        mem_data_out <= (int'(ram_raddr_q) < DEPTH) ? ram[ram_raddr_q] : 32'hBAD0_BAD0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] lane_update(input logic [31:0] old_w, input logic [31:0] new_w,
                                                input logic [3:0] sel);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = sel[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        return r;
    endfunction

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One complete bus transfer with timing and RAM-activity expectations.
    task automatic do_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input int hold, output logic [31:0] rdat);
        logic [AW-1:0] a;
        logic          inr;
        int            exp_lat, exp_en, exp_we, lat, en_cnt, we_cnt;
        logic [31:0]   exp_wd, seen;
        logic          got;
        a = adr[AW-1:0];
        inr = int'(a) < DEPTH;
        exp_wd = inr ? lane_update(ref_mem[a], dat, sel) : 32'h0;
        if (!inr)                      begin exp_lat = 1; exp_en = 0; exp_we = 0; end
        else if (we && sel == 4'hF)    begin exp_lat = 2; exp_en = 1; exp_we = 1; end
        else if (we && sel == 4'h0)    begin exp_lat = 1; exp_en = 0; exp_we = 0; end
        else if (we)                   begin exp_lat = 5; exp_en = 4; exp_we = 1; end
        else                           begin exp_lat = 4; exp_en = 3; exp_we = 0; end
        if (!we) exp_q.push_back(inr ? ref_mem[a] : 32'h0);

        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
        lat = 0; en_cnt = 0; we_cnt = 0; got = 1'b0; seen = '0;
        while (!got && lat < 20) begin
            cycle();
            lat++;
            if (mem_en) begin
                en_cnt++;
                check("rd_addr", 32'(mem_read_address), 32'(a));
            end
            if (mem_we) begin
                we_cnt++;
                check("wr_addr", 32'(mem_write_address), 32'(a));
                check("wr_data", mem_data_in, exp_wd);
            end
            got = wbs_ack_o;
        end
        check("ack_seen", 32'(got), 32'd1);
        check("ack_latency", 32'(lat), 32'(exp_lat));
        check("en_cycles", 32'(en_cnt), 32'(exp_en));
        check("we_cycles", 32'(we_cnt), 32'(exp_we));
        seen = wbs_dat_o;
        rdat = seen;
        if (!we) check("rdata", seen, exp_q.pop_front());
        for (int i = 0; i < hold; i++) begin
            cycle();
            check("hold_ack", 32'(wbs_ack_o), 32'd1);
            check("hold_dat", wbs_dat_o, seen);
            check("hold_en", 32'(mem_en), 32'd0);
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        cycle();
        check("ack_drop", 32'(wbs_ack_o), 32'd0);
        if (we && inr && got) ref_mem[a] = exp_wd;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"}, 32'(wbs_ack_o), 32'd0);
        check({tag, "_dat"}, wbs_dat_o, 32'd0);
        check({tag, "_en"}, 32'(mem_en), 32'd0);
        check({tag, "_we"}, 32'(mem_we), 32'd0);
        check({tag, "_waddr"}, 32'(mem_write_address), 32'd0);
        check({tag, "_raddr"}, 32'(mem_read_address), 32'd0);
        check({tag, "_din"}, mem_data_in, 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        int acks, wes, ens;
        logic        wr;
        logic [31:0] adr;
        logic [3:0]  sel;

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed_word(i);
        ram_init = 1'b1;
        @(negedge clk);
        ram_init = 1'b0;
        cycle();
        check_all_zero("reset");
        rst = 1'b0;
        cycle();

        // Full write then read back.
        do_xfer(1'b1, 32'd5, 32'hDEADBEEF, 4'hF, 0, rd);
        do_xfer(1'b0, 32'd5, 32'h0, 4'h0, 0, rd);
        check("fw_literal", rd, 32'hDEADBEEF);

        // Partial write merged with stored word.
        do_xfer(1'b1, 32'd7, 32'h11223344, 4'hF, 0, rd);
        do_xfer(1'b1, 32'd7, 32'hAABBCCDD, 4'b0101, 0, rd);
        do_xfer(1'b0, 32'd7, 32'h0, 4'h0, 0, rd);
        check("pw_literal", rd, 32'h11BB33DD);

        // Out of range and high address bits ignored.
        do_xfer(1'b0, 32'd1024, 32'h0, 4'h0, 0, rd);
        do_xfer(1'b1, 32'd2000, 32'h12345678, 4'hF, 0, rd);
        do_xfer(1'b0, 32'hABCD_0005, 32'h0, 4'h0, 0, rd);
        do_xfer(1'b1, 32'd11, 32'hFFFFFFFF, 4'h0, 0, rd);

        // Abort a read-modify-write while it is still reading.
        for (int k = 1; k <= 2; k++) begin
            wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
            wbs_adr_i = 32'd9; wbs_dat_i = 32'h55667788; wbs_sel_i = 4'b0011;
            acks = 0; wes = 0;
            for (int c = 0; c < k; c++) begin
                cycle();
                if (wbs_ack_o) acks++;
                if (mem_we) wes++;
            end
            wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
            for (int c = 0; c < 6; c++) begin
                cycle();
                if (wbs_ack_o) acks++;
                if (mem_we) wes++;
            end
            check("abort_ack", 32'(acks), 32'd0);
            check("abort_we", 32'(wes), 32'd0);
            do_xfer(1'b0, 32'd9, 32'h0, 4'h0, 0, rd);
        end

        // Reset in the middle of a read.
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = 32'd5; wbs_sel_i = 4'hF;
        cycle();
        cycle();
        rst = 1'b1; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        cycle();
        check_all_zero("midrst");
        rst = 1'b0;
        cycle();
        do_xfer(1'b0, 32'd5, 32'h0, 4'h0, 0, rd);

        // Ack held while stb stays high.
        do_xfer(1'b0, 32'd7, 32'h0, 4'h0, 5, rd);
        do_xfer(1'b1, 32'd20, 32'hCAFEF00D, 4'b1001, 5, rd);
        do_xfer(1'b0, 32'd20, 32'h0, 4'h0, 0, rd);

        // Random traffic over a small address window plus some out-of-range.
        for (int n = 0; n < 150; n++) begin
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) adr = 32'($urandom_range(DEPTH, (1 << AW) - 1));
            else adr = 32'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) adr[31:AW] = 19'($urandom);
            case ($urandom_range(0, 3))
                0:       sel = 4'hF;
                1:       sel = 4'h0;
                default: sel = 4'($urandom);
            endcase
            do_xfer(wr, adr, $urandom, sel, $urandom_range(0, 2), rd);
            if ($urandom_range(0, 1) == 1) cycle();
        end

        ens = 0;
        for (int c = 0; c < 4; c++) begin
            cycle();
            if (mem_en || wbs_ack_o) ens++;
        end
        check("idle_quiet", 32'(ens), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
